// File: rtl/wash_seq_timer_if.sv
// Command/status bundle between the panel key decoder (master) and wash_seq_timer (slave).
// The delay_s field is present only when DELAY_START_EN is defined.
interface wash_seq_timer_if #(
   parameter int unsigned TW = 8
);
   logic          power;
   logic          start;
   logic          pause;
   logic          abort;
   logic [2:0]    mode_sel;
   logic [2:0]    water_lvl;
   logic [1:0]    rinse_num;
`ifdef DELAY_START_EN
   logic [TW-1:0] delay_s;
`endif
   logic [2:0]    state;
   logic [1:0]    rinse_idx;
   logic [TW-1:0] phase_time;
   logic [TW-1:0] total_time;
   logic          in_water;
   logic          out_water;
   logic          done;

   modport master (
      output power, start, pause, abort, mode_sel, water_lvl, rinse_num,
`ifdef DELAY_START_EN
      output delay_s,
`endif
      input  state, rinse_idx, phase_time, total_time, in_water, out_water, done
   );

   modport slave (
      input  power, start, pause, abort, mode_sel, water_lvl, rinse_num,
`ifdef DELAY_START_EN
      input  delay_s,
`endif
      output state, rinse_idx, phase_time, total_time, in_water, out_water, done
   );
endinterface

// File: rtl/wash_seq_timer.sv
// Washing-cycle sequencer: WASH -> RINSE xN -> SPIN, timed in 1 s ticks with pause/resume/abort.
// Define DELAY_START_EN to add the delayed-start DELAY state and the delay_s input.
module wash_seq_timer #(
   parameter int unsigned TICK_DIV   = 100_000_000,
   parameter int unsigned TW         = 8,
   parameter int unsigned WASH_BASE  = 9,
   parameter int unsigned RINSE_BASE = 9,
   parameter int unsigned SPIN_BASE  = 3,
   parameter int unsigned DRAIN_PRE  = 3
) (
   input logic             clk,
   input logic             rst_n,
   wash_seq_timer_if.slave bus
);
   localparam int unsigned   CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WASH  = 3'd1,
      S_RINSE = 3'd2,
      S_SPIN  = 3'd3,
      S_PAUSE = 3'd4,
      S_DONE  = 3'd5
`ifdef DELAY_START_EN
      , S_DELAY = 3'd6
`endif
   } state_e;

   state_e        state_q, state_d, ret_q, ret_d;
   logic [1:0]    idx_q, idx_d;
   logic [TW-1:0] phase_q, phase_d, total_q, total_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    mode_q, mode_d, water_q, water_d;
   logic [1:0]    rnum_q, rnum_d;
   logic          in_q, in_d, out_q, out_d;
   logic          is_delay, running, tick;
   logic [1:0]    rnum_live;
   logic [TW-1:0] el, w_t;

   function automatic logic [TW-1:0] dur(input state_e s, input logic [2:0] w);
      case (s)
         S_WASH:  return TW'(WASH_BASE) + TW'(w);
         S_RINSE: return TW'(RINSE_BASE) + TW'(w) + TW'(w);
         S_SPIN:  return TW'(SPIN_BASE) + TW'(w);
         default: return '0;
      endcase
   endfunction

   function automatic state_e first_phase(input logic [2:0] m);
      if (m[0])      return S_WASH;
      else if (m[1]) return S_RINSE;
      else if (m[2]) return S_SPIN;
      else           return S_DONE;
   endfunction

   function automatic state_e after_rinse(input logic [2:0] m);
      return m[2] ? S_SPIN : S_DONE;
   endfunction

   function automatic logic [TW-1:0] total_of(input logic [2:0] m, input logic [2:0] w,
                                              input logic [1:0] rn);
      logic [TW-1:0] t;
      logic [TW-1:0] r;
      t = '0;
      r = dur(S_RINSE, w);
      if (m[0]) t = t + dur(S_WASH, w);
      if (m[1]) begin
         case (rn)
            2'd2:    t = t + r + r;
            2'd3:    t = t + r + r + r;
            default: t = t + r;
         endcase
      end
      if (m[2]) t = t + dur(S_SPIN, w);
      return t;
   endfunction

`ifdef DELAY_START_EN
   assign is_delay = (state_q == S_DELAY);
`else
   assign is_delay = 1'b0;
`endif
   assign running   = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN) || is_delay;
   assign tick      = running && (cnt_q == CNT_MAX);
   assign rnum_live = (bus.rinse_num == 2'd0) ? 2'd1 : bus.rinse_num;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      idx_d   = idx_q;
      phase_d = phase_q;
      total_d = total_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      water_d = water_q;
      rnum_d  = rnum_q;
      if (running) cnt_d = tick ? '0 : cnt_q + CW'(1);

      case (state_q)
         S_IDLE: begin
            if (bus.start && (bus.mode_sel != '0)) begin
               mode_d  = bus.mode_sel;
               water_d = bus.water_lvl;
               rnum_d  = rnum_live;
               cnt_d   = '0;
               idx_d   = '0;
               total_d = total_of(bus.mode_sel, bus.water_lvl, rnum_live);
               state_d = first_phase(bus.mode_sel);
               phase_d = dur(state_d, bus.water_lvl);
`ifdef DELAY_START_EN
               if (bus.delay_s != '0) begin
                  state_d = S_DELAY;
                  phase_d = bus.delay_s;
               end
`endif
            end
         end
         S_PAUSE: if (bus.start) state_d = ret_q;
         S_DONE: begin
            cnt_d = '0;
            if (bus.start) state_d = S_IDLE;
         end
         default: begin
            if (tick) begin
               if (!is_delay) total_d = total_q - TW'(1);
               if (phase_q > TW'(1)) begin
                  phase_d = phase_q - TW'(1);
               end else begin
                  case (state_q)
                     S_WASH: begin
                        state_d = mode_q[1] ? S_RINSE : after_rinse(mode_q);
                        idx_d   = '0;
                     end
                     S_RINSE: begin
                        if (({1'b0, idx_q} + 3'd1) < {1'b0, rnum_q}) begin
                           state_d = S_RINSE;
                           idx_d   = idx_q + 2'd1;
                        end else begin
                           state_d = after_rinse(mode_q);
                        end
                     end
                     S_SPIN:  state_d = S_DONE;
                     default: state_d = first_phase(mode_q);
                  endcase
                  phase_d = dur(state_d, water_q);
               end
            end
            // A tick in the same cycle is applied first; the post-tick state is what resumes.
            if (bus.pause && (state_d != S_DONE)) begin
               ret_d   = state_d;
               state_d = S_PAUSE;
            end
         end
      endcase

      if (bus.abort || !bus.power) state_d = S_IDLE;

      if (state_d == S_IDLE) begin
         phase_d = dur(first_phase(bus.mode_sel), bus.water_lvl);
         total_d = total_of(bus.mode_sel, bus.water_lvl, rnum_live);
         cnt_d   = '0;
         idx_d   = '0;
      end else if (state_d == S_DONE) begin
         phase_d = '0;
         total_d = '0;
         cnt_d   = '0;
      end
   end

   // Indicators are registered from the next phase/time so they line up with phase_time.
   always_comb begin
      in_d  = 1'b0;
      out_d = 1'b0;
      w_t   = TW'(water_d);
      el    = dur(state_d, water_d) - phase_d;
      case (state_d)
         S_WASH:  in_d = (el < w_t);
         S_RINSE: begin
            out_d = (el < w_t + TW'(DRAIN_PRE));
            in_d  = !out_d && (el < w_t + w_t + TW'(DRAIN_PRE));
         end
         S_SPIN:  out_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         idx_q   <= '0;
         phase_q <= '0;
         total_q <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         water_q <= '0;
         rnum_q  <= '0;
         in_q    <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         total_q <= total_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         water_q <= water_d;
         rnum_q  <= rnum_d;
         in_q    <= in_d;
         out_q   <= out_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.rinse_idx  = idx_q;
   assign bus.phase_time = phase_q;
   assign bus.total_time = total_q;
   assign bus.in_water   = in_q;
   assign bus.out_water  = out_q;
   assign bus.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_wash_seq_timer.sv
// Directed bench for wash_seq_timer with TICK_DIV=4; expected values are hand-computed.
// The delayed-start scenario is exercised only when DELAY_START_EN is defined.
module tb_wash_seq_timer;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   logic        any_in;

   wash_seq_timer_if #(.TW(8)) bus ();

   wash_seq_timer #(.TICK_DIV(4), .TW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic pulse_abort();
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   task automatic idle_setup(input logic [2:0] m, input logic [2:0] w, input logic [1:0] rn);
      bus.mode_sel  = m;
      bus.water_lvl = w;
      bus.rinse_num = rn;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.power     = 1'b1;
      bus.start     = 1'b0;
      bus.pause     = 1'b0;
      bus.abort     = 1'b0;
      bus.mode_sel  = 3'b111;
      bus.water_lvl = 3'd2;
      bus.rinse_num = 2'd2;
`ifdef DELAY_START_EN
      bus.delay_s   = '0;
`endif
      @(negedge clk);
      check("rst_state", bus.state, 0);
      check("rst_phase", bus.phase_time, 0);
      check("rst_total", bus.total_time, 0);
      check("rst_water", {bus.in_water, bus.out_water}, 0);
      check("rst_done", bus.done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_phase", bus.phase_time, 11);
      check("idle_total", bus.total_time, 42);

      // Full cycle: WASH 11, RINSE 13 x2, SPIN 5 -> 42 s = 168 cycles
      pulse_start();
      check("c1_state0", bus.state, 1);
      check("c1_phase0", bus.phase_time, 11);
      check("c1_total0", bus.total_time, 42);
      check("c1_in0", bus.in_water, 1);
      for (int k = 1; k <= 168; k++) begin
         @(negedge clk);
         if (k == 8) begin
            check("c1_phase8", bus.phase_time, 9);
            check("c1_total8", bus.total_time, 40);
            check("c1_in8", bus.in_water, 0);
         end
         if (k == 44) begin
            check("c1_rinse0", bus.state, 2);
            check("c1_idx0", bus.rinse_idx, 0);
            check("c1_rphase", bus.phase_time, 13);
            check("c1_rtotal", bus.total_time, 31);
            check("c1_rout", bus.out_water, 1);
         end
         if (k == 64) check("c1_fill_el5", {bus.in_water, bus.out_water}, 2'b10);
         if (k == 72) check("c1_off_el7", {bus.in_water, bus.out_water}, 2'b00);
         if (k == 96) begin
            check("c1_rinse1", bus.state, 2);
            check("c1_idx1", bus.rinse_idx, 1);
            check("c1_r1phase", bus.phase_time, 13);
            check("c1_r1total", bus.total_time, 18);
         end
         if (k == 148) begin
            check("c1_spin", bus.state, 3);
            check("c1_sphase", bus.phase_time, 5);
            check("c1_stotal", bus.total_time, 5);
            check("c1_sout", bus.out_water, 1);
         end
         if (k == 167) check("c1_last_s", bus.phase_time, 1);
         if (k == 168) begin
            check("c1_done_state", bus.state, 5);
            check("c1_done", bus.done, 1);
            check("c1_done_times", {bus.phase_time, bus.total_time}, 0);
            check("c1_done_water", {bus.in_water, bus.out_water}, 0);
         end
      end
      pulse_start();
      check("c1_clear", bus.state, 0);
      check("c1_clear_done", bus.done, 0);

      // Wash only, water 0: never fills, DONE after 9 ticks
      idle_setup(3'b001, 3'd0, 2'd1);
      check("c2_idle_total", bus.total_time, 9);
      pulse_start();
      any_in = bus.in_water;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         any_in = any_in | bus.in_water;
         if (k == 35) check("c2_still_wash", bus.state, 1);
         if (k == 36) check("c2_done", bus.state, 5);
      end
      check("c2_no_fill", any_in, 0);
      pulse_start();
      check("c2_clear", bus.state, 0);

      // rinse_num 0 counts as one rinse; mode 0 start ignored
      idle_setup(3'b010, 3'd0, 2'd0);
      check("rn0_total", bus.total_time, 9);
      idle_setup(3'b000, 3'd2, 2'd2);
      check("m0_phase", bus.phase_time, 0);
      pulse_start();
      check("m0_ignored", bus.state, 0);

      // Rinse water 3: drain el 0..5, fill el 6..8, idle el 9..14
      idle_setup(3'b010, 3'd3, 2'd1);
      pulse_start();
      for (int e = 0; e < 15; e++) begin
         check($sformatf("c3_el%0d", e), {bus.in_water, bus.out_water},
               (e < 6) ? 2'b01 : ((e < 9) ? 2'b10 : 2'b00));
         repeat (4) @(negedge clk);
      end
      check("c3_done", bus.state, 5);
      pulse_abort();
      check("c3_abort_done", bus.state, 0);

      // Pause at phase_time 7 with count 2 held, resume, next tick 2 cycles later
      idle_setup(3'b001, 3'd0, 2'd1);
      pulse_start();
      repeat (9) @(negedge clk);
      bus.pause = 1'b1;
      @(negedge clk);
      bus.pause = 1'b0;
      check("c4_paused", bus.state, 4);
      check("c4_phase", bus.phase_time, 7);
      repeat (40) @(negedge clk);
      check("c4_held_state", bus.state, 4);
      check("c4_held_phase", bus.phase_time, 7);
      check("c4_held_total", bus.total_time, 7);
      pulse_start();
      check("c4_resumed", bus.state, 1);
      @(negedge clk);
      check("c4_pre_tick", bus.phase_time, 7);
      @(negedge clk);
      check("c4_tick", bus.phase_time, 6);
      pulse_abort();

      // Pause on the tick cycle: tick applied, then paused
      idle_setup(3'b001, 3'd0, 2'd1);
      pulse_start();
      repeat (3) @(negedge clk);
      bus.pause = 1'b1;
      @(negedge clk);
      bus.pause = 1'b0;
      check("c5_state", bus.state, 4);
      check("c5_phase", bus.phase_time, 8);
      check("c5_total", bus.total_time, 8);
      pulse_abort();

      // Pause + abort together mid-WASH goes to IDLE
      idle_setup(3'b001, 3'd2, 2'd1);
      pulse_start();
      repeat (5) @(negedge clk);
      bus.pause = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      check("c6_abort_state", bus.state, 0);
      check("c6_abort_water", {bus.in_water, bus.out_water}, 0);

      // Power loss mid-SPIN
      idle_setup(3'b100, 3'd1, 2'd1);
      pulse_start();
      repeat (3) @(negedge clk);
      check("c7_spin", bus.state, 3);
      check("c7_spin_out", bus.out_water, 1);
      bus.power = 1'b0;
      @(negedge clk);
      check("c7_off_state", bus.state, 0);
      check("c7_off_water", {bus.in_water, bus.out_water, bus.done}, 0);
      bus.power = 1'b1;

`ifdef DELAY_START_EN
      // Delayed start: 3 s DELAY, then SPIN (3 s)
      idle_setup(3'b100, 3'd0, 2'd1);
      bus.delay_s = 8'd3;
      pulse_start();
      bus.delay_s = '0;
      check("d_state", bus.state, 6);
      check("d_phase", bus.phase_time, 3);
      check("d_total", bus.total_time, 3);
      repeat (11) @(negedge clk);
      check("d_still", bus.state, 6);
      check("d_no_drain", bus.out_water, 0);
      check("d_total_held", bus.total_time, 3);
      @(negedge clk);
      check("d_spin", bus.state, 3);
      check("d_spin_phase", bus.phase_time, 3);
      check("d_spin_out", bus.out_water, 1);
      pulse_abort();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
